// File: rtl/alu_sequencer.sv
// Command front-end for the alu: one operation per handshake, multi-pass shifts,
// and an architectural carry flag that chains ADC/SBB across commands.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module alu_sequencer #(
  parameter int width       = `WORD_WIDTH,
  parameter int flags_width = 5,
  parameter int cnt_width   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_opcode,
  input  logic [width-1:0]       cmd_a,
  input  logic [width-1:0]       cmd_b,
  input  logic [cnt_width-1:0]   cmd_count,
  input  logic                   cmd_use_carry,
  output logic                   alu_oe,
  output logic [3:0]             alu_opcode,
  output logic [width-1:0]       alu_in1,
  output logic [width-1:0]       alu_in2,
  output logic                   alu_carry,
  input  logic [width-1:0]       alu_out,
  input  logic [flags_width-1:0] alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [width-1:0]       rsp_result,
  output logic [flags_width-1:0] rsp_flags,
  output logic                   carry_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             op_reg;
  logic [width-1:0]       acc_reg;
  logic [width-1:0]       op_b_reg;
  logic                   use_c_reg;
  logic [cnt_width-1:0]   remaining_reg;
  logic [flags_width-1:0] flags_reg;
  logic                   carry_reg;

  logic cmd_is_shift;
  logic op_is_shift;
  logic op_is_arith;
  logic cmd_accept;
  logic last_pass;
  logic exec;

  assign cmd_is_shift = (cmd_opcode >= 4'd7) && (cmd_opcode <= 4'd9);
  assign op_is_shift  = (op_reg >= 4'd7) && (op_reg <= 4'd9);
  assign op_is_arith  = (op_reg <= 4'd2);
  assign cmd_accept   = (state_reg == IDLE) && cmd_valid;
  assign last_pass    = (remaining_reg == cnt_width'(1));
  assign exec         = (state_reg == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= 4'd0;
      acc_reg       <= '0;
      op_b_reg      <= '0;
      use_c_reg     <= 1'b0;
      remaining_reg <= '0;
      flags_reg     <= '0;
      carry_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (cmd_accept) begin
            op_reg        <= cmd_opcode;
            acc_reg       <= cmd_a;
            op_b_reg      <= cmd_b;
            use_c_reg     <= cmd_use_carry;
            remaining_reg <= cmd_is_shift ? cmd_count : cnt_width'(1);
          end
        end
        EXEC: begin
          acc_reg       <= alu_out;
          flags_reg     <= alu_flags;
          remaining_reg <= remaining_reg - cnt_width'(1);
          // Architectural carry comes from the final pass only.
          if (last_pass) begin
            carry_reg <= alu_flags[0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_is_shift && (cmd_count == '0)) ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (last_pass) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Alu operand buses are forced to zero whenever no pass is in flight.
  genvar gi;
  generate
    for (gi = 0; gi < width; gi++) begin : g_alu_bus
      assign alu_in1[gi] = exec & acc_reg[gi];
      assign alu_in2[gi] = exec & ~op_is_shift & op_b_reg[gi];
    end
  endgenerate

  assign alu_oe     = exec;
  assign alu_opcode = exec ? op_reg : 4'd0;
  assign alu_carry  = exec & use_c_reg & op_is_arith & carry_reg;

  assign cmd_ready  = (state_reg == IDLE);
  assign rsp_valid  = (state_reg == DONE);
  assign rsp_result = acc_reg;
  assign rsp_flags  = flags_reg;
  assign carry_flag = carry_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a single-pass alu stub closes the loop, and a
// whole-command reference model predicts result, flags, carry and latency.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [4:0]  cmd_count;
  logic        cmd_use_carry;
  logic        alu_oe;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic        alu_carry;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        carry_flag;

  int checks = 0;
  int errors = 0;

  logic [4:0] model_flags;
  logic       model_carry;

  always #5 clk = ~clk;

  alu_sequencer #(.width(16), .flags_width(5), .cnt_width(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count), .cmd_use_carry(cmd_use_carry),
    .alu_oe(alu_oe), .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_carry(alu_carry), .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .carry_flag(carry_flag)
  );

  function automatic logic [4:0] flags_of(input logic [15:0] r, input logic o, input logic c);
    return {~^r, r[15], (r == 16'h0000), o, c};
  endfunction

  // Single-pass alu stub: shifts move exactly one bit per pass.
  always_comb begin
    logic [16:0] t;
    logic        o;
    alu_out   = 16'h0000;
    alu_flags = 5'b00000;
    t = 17'h0;
    o = 1'b0;
    if (alu_oe) begin
      case (alu_opcode)
        4'd0: begin
          t = {1'b0, alu_in1} + {1'b0, alu_in2} + {16'h0, alu_carry};
          o = (alu_in1[15] == alu_in2[15]) && (t[15] != alu_in1[15]);
        end
        4'd1: begin
          t = {1'b0, alu_in1} - {1'b0, alu_in2} - {16'h0, alu_carry};
          o = (alu_in1[15] != alu_in2[15]) && (t[15] != alu_in1[15]);
        end
        4'd2: begin
          t = {1'b0, alu_in2} - {1'b0, alu_in1} - {16'h0, alu_carry};
          o = (alu_in2[15] != alu_in1[15]) && (t[15] != alu_in2[15]);
        end
        4'd3: t = {1'b0, ~alu_in1};
        4'd4: t = {1'b0, alu_in1 & alu_in2};
        4'd5: t = {1'b0, alu_in1 | alu_in2};
        4'd6: t = {1'b0, alu_in1 ^ alu_in2};
        4'd7: t = {alu_in1[15], alu_in1[14:0], 1'b0};
        4'd8: t = {alu_in1[0], 1'b0, alu_in1[15:1]};
        4'd9: t = {alu_in1[0], alu_in1[15], alu_in1[15:1]};
        default: t = 17'h0;
      endcase
      alu_out   = t[15:0];
      alu_flags = flags_of(t[15:0], o, t[16]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-command model computed directly from the operation semantics.
  task automatic ref_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] cnt, input logic usec,
                         output logic [15:0] r, output logic [4:0] f, output logic c,
                         output int lat, output logic shift0);
    logic        cin;
    logic        o;
    logic [47:0] t48;
    logic signed [31:0] sa;
    logic [31:0] t32;
    int n;
    n = int'(cnt);
    cin = (usec && op <= 4'd2) ? model_carry : 1'b0;
    o = 1'b0;
    c = 1'b0;
    r = 16'h0;
    shift0 = (op >= 4'd7 && op <= 4'd9 && cnt == 5'd0);
    lat = (op >= 4'd7 && op <= 4'd9) ? n + 1 : 2;
    case (op)
      4'd0: begin
        r = a + b + 16'(cin);
        c = (int'(a) + int'(b) + int'(cin)) > 65535;
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1: begin
        r = a - b - 16'(cin);
        c = int'(a) < int'(b) + int'(cin);
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: begin
        r = b - a - 16'(cin);
        c = int'(b) < int'(a) + int'(cin);
        o = (a[15] != b[15]) && (r[15] != b[15]);
      end
      4'd3: r = ~a;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin
        t48 = {32'h0, a} << n;
        r = t48[15:0];
        c = t48[16];
      end
      4'd8: begin
        r = a >> n;
        t32 = {16'h0, a} >> (n - 1);
        c = t32[0];
      end
      4'd9: begin
        sa = {{16{a[15]}}, a};
        t32 = sa >>> n;
        r = t32[15:0];
        t32 = sa >>> (n - 1);
        c = t32[0];
      end
      default: r = 16'h0;
    endcase
    if (shift0) begin
      r = a;
      f = model_flags;
      c = model_carry;
    end else begin
      f = flags_of(r, o, c);
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] cnt, input logic usec, input int hold);
    logic [15:0] er;
    logic [4:0]  ef;
    logic        ec;
    logic        s0;
    logic        exp_cin;
    int          elat;
    int          lat;
    ref_cmd(op, a, b, cnt, usec, er, ef, ec, elat, s0);
    exp_cin = (usec && op <= 4'd2) ? model_carry : 1'b0;
    @(negedge clk);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_count = cnt; cmd_use_carry = usec;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    if (s0) begin
      chk("alu_oe_shift0", alu_oe, 0);
    end else begin
      chk("alu_oe_exec", alu_oe, 1);
      chk("alu_opcode", alu_opcode, op);
      chk("alu_in1_first", alu_in1, a);
      chk("alu_in2", alu_in2, (op >= 4'd7 && op <= 4'd9) ? 16'h0 : b);
      chk("alu_carry", alu_carry, exp_cin);
    end
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("rsp_result", rsp_result, er);
    chk("rsp_flags", rsp_flags, ef);
    chk("carry_flag", carry_flag, ec);
    chk("cmd_ready_busy", cmd_ready, 0);
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_opcode = 4'd0; cmd_a = 16'h5555; cmd_b = 16'h1111;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, er);
        chk("hold_flags", rsp_flags, ef);
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_alu_oe", alu_oe, 0);
      end
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    model_flags = ef;
    model_carry = ec;
    $display("txn op=%0d a=%h b=%h cnt=%0d uc=%0d -> result=%h flags=%b carry=%0d lat=%0d",
             op, a, b, cnt, usec, rsp_result, rsp_flags, carry_flag, lat);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 16'h0; cmd_b = 16'h0;
    cmd_count = 5'd0; cmd_use_carry = 1'b0; rsp_ready = 1'b0;
    model_flags = 5'b00000;
    model_carry = 1'b0;
    #12;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_oe", alu_oe, 0);
    chk("reset_carry", carry_flag, 0);
    chk("reset_flags", rsp_flags, 0);
    chk("reset_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(4'd0, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 0);
    chk("t1_carry_set", carry_flag, 1);
    chk("t1_flags", rsp_flags, 5'b10101);
    run_cmd(4'd0, 16'h0000, 16'h0000, 5'd0, 1'b1, 0);
    chk("t2_result", rsp_result, 16'h0001);
    run_cmd(4'd7, 16'h8001, 16'hABCD, 5'd3, 1'b0, 0);
    chk("t3_result", rsp_result, 16'h0008);
    run_cmd(4'd9, 16'h8000, 16'h0000, 5'd15, 1'b0, 0);
    chk("t4_flags", rsp_flags, 5'b11000);
    run_cmd(4'd7, 16'h1234, 16'h0000, 5'd0, 1'b0, 0);
    run_cmd(4'd5, 16'h00F0, 16'h0F00, 5'd0, 1'b0, 5);
    run_cmd(4'd12, 16'h1234, 16'h4321, 5'd0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)));
    end

    run_cmd(4'd0, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 0);
    // Abort a long shift mid-flight with carry_flag known to be 1.
    @(negedge clk);
    cmd_opcode = 4'd8; cmd_a = 16'($urandom); cmd_b = 16'h0; cmd_count = 5'd20;
    cmd_use_carry = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_oe", alu_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_alu_oe", alu_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_flags = 5'b00000;
    model_carry = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", rsp_valid, 0);
    $display("txn reset abort of SHR count=20 at pass 5");
    run_cmd(4'd0, 16'h1234, 16'h1111, 5'd0, 1'b1, 0);
    chk("post_rst_adc", rsp_result, 16'h2345);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
